// File: rtl/cache_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_pkg
// Purpose  : Shared types and helpers for the cache line fill unit.
//            Holds the fill FSM state encoding, the beat count for the
//            default geometry (64-byte line, 32-bit memory bus), and
//            line_align(), which clears the byte-offset bits of an address.
// Revision : 1.0 - initial release
// ============================================================================
package cache_fill_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WB_REQ    = 3'd1,
    ST_FILL_REQ  = 3'd2,
    ST_FILL_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } fill_state_e;

  localparam int LINE_SIZE_BYTES_DEF = 64;
  localparam int MEM_DATA_WIDTH_DEF  = 32;
  localparam int BEATS               = (8 * LINE_SIZE_BYTES_DEF) / MEM_DATA_WIDTH_DEF;
  localparam int BEAT_IDX_W          = $clog2(BEATS);

  // Widest address line_align() accepts; callers zero-extend into it.
  localparam int ADDR_MAX_W = 64;

  function automatic logic [ADDR_MAX_W-1:0] line_align(
    input logic [ADDR_MAX_W-1:0] addr,
    input int unsigned           off_bits
  );
    return addr & ~((64'd1 << off_bits) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_beat_buf.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_beat_buf
// Purpose  : One cache line of storage.
//            It is loaded whole with the victim line, read a beat at a time
//            during writeback, and then overwritten beat by beat during the
//            fill. o_line_next shows the value that will be registered on the
//            coming edge, so the top can capture a completed line on the same
//            edge that stores its final beat.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            i_load/_data   - load the whole line (takes priority over i_wr)
//            i_wr/_idx/_data- write one beat at index i_wr_idx
//            i_rd_idx       - beat index for o_rd_data
//            o_rd_data      - beat selected by i_rd_idx
//            o_line_next    - next-state value of the line register
// Revision : 1.0 - initial release
// ============================================================================
module cache_line_beat_buf #(
  parameter int LINE_BITS = 512,
  parameter int BEAT_BITS = 32,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [LINE_BITS-1:0] i_load_data,
  input  logic                 i_wr,
  input  logic [IDX_W-1:0]     i_wr_idx,
  input  logic [BEAT_BITS-1:0] i_wr_data,
  input  logic [IDX_W-1:0]     i_rd_idx,
  output logic [BEAT_BITS-1:0] o_rd_data,
  output logic [LINE_BITS-1:0] o_line_next
);

  logic [LINE_BITS-1:0] line_q;
  logic [LINE_BITS-1:0] line_d;

  always_comb begin
    line_d = line_q;
    if (i_load) begin
      line_d = i_load_data;
    end else if (i_wr) begin
      line_d[i_wr_idx*BEAT_BITS +: BEAT_BITS] = i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign o_rd_data   = line_q[i_rd_idx*BEAT_BITS +: BEAT_BITS];
  assign o_line_next = line_d;

endmodule
`default_nettype wire

// File: rtl/cache_line_fill_unit.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_fill_unit
// Purpose  : Memory-side refill/writeback engine behind the 4-way cache.
//            On a miss it writes back the dirty victim (if any) one beat at a
//            time, then issues one line read and assembles the returned beats
//            into a line that is handed back with a one-cycle response pulse.
// Config   : CACHE_FILL_TIMEOUT_EN - when defined, a watchdog aborts a
//            transaction after TIMEOUT_CYCLES cycles without progress and
//            returns a zero line with o_mem_error. Otherwise o_mem_error is 0
//            and the engine waits indefinitely.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            i_miss_req/_addr    - fill request and missing address
//            i_evict/_addr/_data - dirty victim to write back first
//            o_busy              - engine not idle
//            o_memory_line       - last completed line (held)
//            o_memory_response   - one-cycle fill-complete pulse
//            o_mem_req/_we/_addr/_wdata, i_mem_ready - memory request channel
//            i_mem_rvalid/_rdata - memory read-beat channel
//            o_mem_error         - timeout pulse, coincident with response
// Revision : 1.0 - initial release
// ============================================================================
module cache_line_fill_unit
  import cache_fill_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int MEM_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_miss_req,
  input  logic [ADDRESS_WIDTH-1:0]     i_miss_addr,
  input  logic                         i_evict,
  input  logic [ADDRESS_WIDTH-1:0]     i_evict_addr,
  input  logic [8*LINE_SIZE_BYTES-1:0] i_evict_data,
  output logic                         o_busy,
  output logic [8*LINE_SIZE_BYTES-1:0] o_memory_line,
  output logic                         o_memory_response,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]     o_mem_addr,
  output logic [MEM_DATA_WIDTH-1:0]    o_mem_wdata,
  input  logic                         i_mem_ready,
  input  logic                         i_mem_rvalid,
  input  logic [MEM_DATA_WIDTH-1:0]    i_mem_rdata,
  output logic                         o_mem_error
);

  localparam int LINE_BITS  = 8 * LINE_SIZE_BYTES;
  localparam int LINE_BEATS = LINE_BITS / MEM_DATA_WIDTH;
  localparam int IDX_W      = $clog2(LINE_BEATS);
  localparam int OFF_BITS   = $clog2(LINE_SIZE_BYTES);
  localparam int BEAT_SHIFT = $clog2(MEM_DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_BEATS - 1);

  fill_state_e              state_q, state_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] miss_line_q, miss_line_d;
  logic [ADDRESS_WIDTH-1:0] evict_line_q, evict_line_d;
  logic [LINE_BITS-1:0]     line_q, line_d;

  logic                      w_handshake;
  logic                      w_last;
  logic                      w_buf_load;
  logic                      w_buf_wr;
  logic [MEM_DATA_WIDTH-1:0] w_buf_rd;
  logic [LINE_BITS-1:0]      w_buf_next;
  logic [ADDRESS_WIDTH-1:0]  w_miss_line;
  logic [ADDRESS_WIDTH-1:0]  w_evict_line;

`ifdef CACHE_FILL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            w_progress;
`endif

  assign w_miss_line  = ADDRESS_WIDTH'(line_align(ADDR_MAX_W'(i_miss_addr), OFF_BITS));
  assign w_evict_line = ADDRESS_WIDTH'(line_align(ADDR_MAX_W'(i_evict_addr), OFF_BITS));

  assign w_handshake = o_mem_req & i_mem_ready;
  assign w_last      = (cnt_q == LAST_BEAT);

  // The victim line and the incoming fill share one buffer: writeback always
  // finishes before the first fill beat can arrive.
  cache_line_beat_buf #(
    .LINE_BITS (LINE_BITS),
    .BEAT_BITS (MEM_DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_beat_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_buf_load),
    .i_load_data (i_evict_data),
    .i_wr        (w_buf_wr),
    .i_wr_idx    (cnt_q),
    .i_wr_data   (i_mem_rdata),
    .i_rd_idx    (cnt_q),
    .o_rd_data   (w_buf_rd),
    .o_line_next (w_buf_next)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_line_d  = miss_line_q;
    evict_line_d = evict_line_q;
    line_d       = line_q;
    w_buf_load   = 1'b0;
    w_buf_wr     = 1'b0;
`ifdef CACHE_FILL_TIMEOUT_EN
    wd_d         = '0;
    err_d        = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_miss_req) begin
          miss_line_d  = w_miss_line;
          evict_line_d = w_evict_line;
          w_buf_load   = 1'b1;
          cnt_d        = '0;
          state_d      = i_evict ? ST_WB_REQ : ST_FILL_REQ;
        end
      end
      ST_WB_REQ: begin
        if (w_handshake) begin
          // Wraps to zero after the last beat, ready for the fill.
          cnt_d = cnt_q + 1'b1;
          if (w_last) begin
            state_d = ST_FILL_REQ;
          end
        end
      end
      ST_FILL_REQ: begin
        if (w_handshake) begin
          cnt_d   = '0;
          state_d = ST_FILL_WAIT;
        end
      end
      ST_FILL_WAIT: begin
        if (i_mem_rvalid) begin
          w_buf_wr = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (w_last) begin
            line_d  = w_buf_next;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
`ifdef CACHE_FILL_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef CACHE_FILL_TIMEOUT_EN
    // Counts consecutive cycles without a handshake or read beat while the
    // engine is waiting on memory; any progress restarts the count.
    if ((state_q == ST_WB_REQ) || (state_q == ST_FILL_REQ) ||
        (state_q == ST_FILL_WAIT)) begin
      if (!w_progress) begin
        if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_RESP;
          line_d  = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
    end
`endif
  end

`ifdef CACHE_FILL_TIMEOUT_EN
  assign w_progress = w_handshake | ((state_q == ST_FILL_WAIT) & i_mem_rvalid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign o_mem_error = err_q;
`else
  assign o_mem_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      miss_line_q  <= '0;
      evict_line_q <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_line_q  <= miss_line_d;
      evict_line_q <= evict_line_d;
      line_q       <= line_d;
    end
  end

  always_comb begin
    o_mem_addr = '0;
    if (state_q == ST_WB_REQ) begin
      o_mem_addr = evict_line_q + (ADDRESS_WIDTH'(cnt_q) << BEAT_SHIFT);
    end else if (state_q == ST_FILL_REQ) begin
      o_mem_addr = miss_line_q;
    end
  end

  assign o_busy            = (state_q != ST_IDLE);
  assign o_mem_req         = (state_q == ST_WB_REQ) || (state_q == ST_FILL_REQ);
  assign o_mem_we          = (state_q == ST_WB_REQ);
  assign o_mem_wdata       = o_mem_we ? w_buf_rd : '0;
  assign o_memory_response = (state_q == ST_RESP);
  assign o_memory_line     = line_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_fill_unit.sv
`timescale 1ns/1ps
`default_nettype none
module tb_cache_line_fill_unit;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_miss_req = 1'b0;
  logic [31:0]   i_miss_addr = '0;
  logic          i_evict = 1'b0;
  logic [31:0]   i_evict_addr = '0;
  logic [511:0]  i_evict_data = '0;
  logic          o_busy;
  logic [511:0]  o_memory_line;
  logic          o_memory_response;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [31:0]   o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic          i_mem_ready = 1'b0;
  logic          i_mem_rvalid = 1'b0;
  logic [31:0]   i_mem_rdata = '0;
  logic          o_mem_error;

  cache_line_fill_unit dut (
    .clk               (clk),
    .rst               (rst),
    .i_miss_req        (i_miss_req),
    .i_miss_addr       (i_miss_addr),
    .i_evict           (i_evict),
    .i_evict_addr      (i_evict_addr),
    .i_evict_data      (i_evict_data),
    .o_busy            (o_busy),
    .o_memory_line     (o_memory_line),
    .o_memory_response (o_memory_response),
    .o_mem_req         (o_mem_req),
    .o_mem_we          (o_mem_we),
    .o_mem_addr        (o_mem_addr),
    .o_mem_wdata       (o_mem_wdata),
    .i_mem_ready       (i_mem_ready),
    .i_mem_rvalid      (i_mem_rvalid),
    .i_mem_rdata       (i_mem_rdata),
    .o_mem_error       (o_mem_error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [511:0] line; logic err; } resp_t;

  wr_t         exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  resp_t       exp_resp_q[$];

  int tests_run = 0;
  int fails = 0;
  int n_reads = 0;
  int n_writes = 0;
  int n_resp = 0;

  // memory model controls
  int          ready_mode = 0;   // 0 = always ready, 1 = toggle, 2 = never
  logic [31:0] rd_base = '0;
  bit          rd_active = 0;
  int          rd_beat = 0;
  bit          rdy = 0;
  bit          resp_due = 0;
  bit          prev_resp = 0;
  bit          stall_v = 0;
  logic [31:0] st_addr, st_wdata;
  logic        st_we;

  // Memory model + scoreboard: inputs driven and outputs sampled on negedge.
  always @(negedge clk) begin
    if (rst) begin
      rd_active = 0; rd_beat = 0; rdy = 0; resp_due = 0; prev_resp = 0; stall_v = 0;
      i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    end else begin
      if (prev_resp) begin
        tests_run++;
        if (o_memory_response !== 1'b0) begin
          fails++; $display("FAIL resp_width: response=%b required 0", o_memory_response);
        end
      end
      if (resp_due) begin
        tests_run++;
        if (o_memory_response !== 1'b1) begin
          fails++; $display("FAIL resp_latency: response=%b required 1 one cycle after last beat", o_memory_response);
        end
        resp_due = 0;
      end
      if (o_memory_response === 1'b1) begin
        resp_t e;
        n_resp++;
        tests_run++;
        if (exp_resp_q.size() == 0) begin
          fails++; $display("FAIL resp_unexpected: response with no expected line");
        end else begin
          e = exp_resp_q.pop_front();
          if (o_memory_line !== e.line || o_mem_error !== e.err) begin
            fails++; $display("FAIL resp_line: line=%h err=%b required line=%h err=%b",
                              o_memory_line, o_mem_error, e.line, e.err);
          end
        end
      end
      prev_resp = o_memory_response;

      if (stall_v && o_mem_req === 1'b1) begin
        tests_run++;
        if (o_mem_addr !== st_addr || o_mem_we !== st_we || o_mem_wdata !== st_wdata) begin
          fails++; $display("FAIL stall_hold: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                            o_mem_addr, o_mem_we, o_mem_wdata, st_addr, st_we, st_wdata);
        end
      end
      stall_v = 0;

      i_mem_rvalid = 1'b0;
      if (rd_active) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = rd_base + 32'(rd_beat);
        rd_beat++;
        if (rd_beat == 16) begin
          rd_active = 0;
          resp_due  = 1;
        end
      end

      case (ready_mode)
        0:       rdy = 1;
        1:       rdy = ~rdy;
        default: rdy = 0;
      endcase
      i_mem_ready = rdy;

      if (o_mem_req === 1'b1) begin
        if (!rdy) begin
          stall_v = 1; st_addr = o_mem_addr; st_we = o_mem_we; st_wdata = o_mem_wdata;
        end else if (o_mem_we === 1'b1) begin
          wr_t w;
          n_writes++;
          tests_run++;
          if (exp_wr_q.size() == 0) begin
            fails++; $display("FAIL wr_unexpected: write addr=%h data=%h", o_mem_addr, o_mem_wdata);
          end else begin
            w = exp_wr_q.pop_front();
            if (o_mem_addr !== w.addr || o_mem_wdata !== w.data) begin
              fails++; $display("FAIL wr_beat: addr=%h data=%h required addr=%h data=%h",
                                o_mem_addr, o_mem_wdata, w.addr, w.data);
            end
          end
        end else begin
          n_reads++;
          tests_run++;
          if (exp_rd_q.size() == 0 || exp_wr_q.size() != 0) begin
            fails++; $display("FAIL rd_unexpected: read addr=%h pending_writes=%0d", o_mem_addr, exp_wr_q.size());
          end else begin
            logic [31:0] a;
            a = exp_rd_q.pop_front();
            if (o_mem_addr !== a) begin
              fails++; $display("FAIL rd_addr: addr=%h required %h", o_mem_addr, a);
            end
          end
          rd_active = 1;
          rd_beat   = 0;
          // Read data in the same cycle as the request handshake must be ignored.
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = 32'hDEAD_BEEF;
        end
      end
    end
  end

  task automatic start_miss(input logic [31:0] addr, input logic ev,
                            input logic [31:0] eaddr, input logic [511:0] edata);
    @(negedge clk);
    i_miss_addr = addr; i_evict = ev; i_evict_addr = eaddr; i_evict_data = edata;
    i_miss_req = 1'b1;
  endtask

  task automatic wait_resp(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (n_resp >= target) begin ok = 1; break; end
    end
  endtask

  function automatic logic [511:0] ramp_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({o_busy, o_memory_response, o_mem_req, o_mem_we, o_mem_error} !== 5'b0 ||
        o_memory_line !== '0 || o_mem_addr !== '0 || o_mem_wdata !== '0) begin
      fails++; $display("FAIL reset_outputs: busy=%b resp=%b req=%b we=%b err=%b addr=%h required all 0",
                        o_busy, o_memory_response, o_mem_req, o_mem_we, o_mem_error, o_mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_miss();
    bit ok; int r0; logic [511:0] l;
    ready_mode = 0; rd_base = 32'h0;
    l = ramp_line(32'h0);
    exp_rd_q.push_back(32'h0000_1200);
    exp_resp_q.push_back('{l, 1'b0});
    r0 = n_reads;
    start_miss(32'h0000_1234, 1'b0, 32'h0, {16{32'h5A5A_5A5A}});
    @(negedge clk); #1;
    tests_run++;
    if (o_busy !== 1'b1 || o_mem_req !== 1'b1 || o_mem_we !== 1'b0 || o_mem_addr !== 32'h0000_1200) begin
      fails++; $display("FAIL clean_req: busy=%b req=%b we=%b addr=%h required 1 1 0 00001200",
                        o_busy, o_mem_req, o_mem_we, o_mem_addr);
    end
    wait_resp(n_resp + 1, 60, ok);
    i_miss_req = 1'b0;
    tests_run++;
    if (!ok) begin fails++; $display("FAIL clean_timeout: no response within 60 cycles"); end
    tests_run++;
    if (n_reads - r0 != 1) begin fails++; $display("FAIL clean_reads: reads=%0d required 1", n_reads - r0); end
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (o_memory_line !== l || o_busy !== 1'b0) begin
      fails++; $display("FAIL line_hold: line=%h busy=%b required line=%h busy=0", o_memory_line, o_busy, l);
    end
  endtask

  task automatic dirty_miss(input logic [31:0] eaddr, input logic [31:0] maddr,
                            input logic [511:0] edata, input int mode, input string nm);
    bit ok; int w0; logic [31:0] ebase, mline;
    ebase = eaddr & ~32'h3F; mline = maddr & ~32'h3F;
    ready_mode = mode; rd_base = $urandom;
    for (int k = 0; k < 16; k++) exp_wr_q.push_back('{ebase + 32'(4*k), edata[k*32 +: 32]});
    exp_rd_q.push_back(mline);
    exp_resp_q.push_back('{ramp_line(rd_base), 1'b0});
    w0 = n_writes;
    start_miss(maddr, 1'b1, eaddr, edata);
    wait_resp(n_resp + 1, 120, ok);
    i_miss_req = 1'b0;
    tests_run++;
    if (!ok) begin fails++; $display("FAIL %s_timeout: no response within 120 cycles", nm); end
    tests_run++;
    if (n_writes - w0 != 16 || exp_wr_q.size() != 0) begin
      fails++; $display("FAIL %s_writes: writes=%0d left=%0d required 16 and 0", nm, n_writes - w0, exp_wr_q.size());
    end
  endtask

  task automatic test_dirty_miss();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'hA0 + 32'(k);
    dirty_miss(32'h0004_0024, 32'h0000_1200, d, 0, "dirty");
  endtask

  task automatic test_wb_stall();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    dirty_miss(32'h0008_0000, 32'h0000_3FBC, d, 1, "wb_stall");
  endtask

  task automatic test_reset_mid_fill();
    bit ok; bit hit;
    ready_mode = 0; rd_base = 32'h0000_2000;
    exp_rd_q.push_back(32'h0000_5500);
    start_miss(32'h0000_5510, 1'b0, 32'h0, '0);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (rd_active && rd_beat >= 8) begin hit = 1; break; end
    end
    tests_run++;
    if (!hit) begin fails++; $display("FAIL midrst_wait: beat 7 never driven"); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({o_busy, o_memory_response, o_mem_req, o_mem_we, o_mem_error} !== 5'b0 ||
        o_memory_line !== '0 || o_mem_addr !== '0 || o_mem_wdata !== '0) begin
      fails++; $display("FAIL midrst_outputs: busy=%b req=%b addr=%h line=%h required all 0",
                        o_busy, o_mem_req, o_mem_addr, o_memory_line);
    end
    i_miss_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_base = 32'h0000_9000;
    exp_rd_q.push_back(32'h0000_5540);
    exp_resp_q.push_back('{ramp_line(32'h0000_9000), 1'b0});
    start_miss(32'h0000_5540, 1'b0, 32'h0, '0);
    wait_resp(n_resp + 1, 60, ok);
    i_miss_req = 1'b0;
    tests_run++;
    if (!ok) begin fails++; $display("FAIL midrst_refill: no response within 60 cycles"); end
  endtask

  task automatic test_held_req();
    bit ok; int r0;
    ready_mode = 0; rd_base = 32'h0000_3000;
    for (int t = 0; t < 2; t++) begin
      exp_rd_q.push_back(32'h0000_6600);
      exp_resp_q.push_back('{ramp_line(32'h0000_3000), 1'b0});
    end
    r0 = n_reads;
    start_miss(32'h0000_6600, 1'b0, 32'h0, '0);
    wait_resp(n_resp + 1, 60, ok);
    tests_run++;
    if (!ok || n_reads - r0 != 1) begin
      fails++; $display("FAIL held_first: ok=%b reads=%0d required 1 and 1", ok, n_reads - r0);
    end
    @(negedge clk); #1;
    tests_run++;
    if (o_busy !== 1'b0) begin fails++; $display("FAIL held_idle: busy=%b required 0", o_busy); end
    @(negedge clk); #1;
    tests_run++;
    if (o_busy !== 1'b1 || o_mem_req !== 1'b1 || o_mem_addr !== 32'h0000_6600) begin
      fails++; $display("FAIL held_restart: busy=%b req=%b addr=%h required 1 1 00006600", o_busy, o_mem_req, o_mem_addr);
    end
    i_miss_req = 1'b0;
    wait_resp(n_resp + 1, 60, ok);
    tests_run++;
    if (!ok || n_reads - r0 != 2) begin
      fails++; $display("FAIL held_second: ok=%b reads=%0d required 1 and 2", ok, n_reads - r0);
    end
  endtask

  task automatic test_timeout();
    bit ok; int cnt; int p0;
    ready_mode = 2; cnt = 0; p0 = n_resp;
`ifdef CACHE_FILL_TIMEOUT_EN
    exp_resp_q.push_back('{512'b0, 1'b1});
    start_miss(32'h0000_7700, 1'b0, 32'h0, '0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (o_memory_response === 1'b1) break;
      if (o_mem_req === 1'b1) cnt++;
    end
    i_miss_req = 1'b0;
    ready_mode = 0;
    tests_run++;
    if (n_resp - p0 != 1 || cnt != 256) begin
      fails++; $display("FAIL timeout_abort: responses=%0d stalled=%0d required 1 and 256", n_resp - p0, cnt);
    end
    @(negedge clk); #1;
    tests_run++;
    if (o_mem_error !== 1'b0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL timeout_pulse: err=%b busy=%b required 0 0", o_mem_error, o_busy);
    end
`else
    rd_base = 32'h0000_4000;
    exp_rd_q.push_back(32'h0000_7700);
    exp_resp_q.push_back('{ramp_line(32'h0000_4000), 1'b0});
    start_miss(32'h0000_7700, 1'b0, 32'h0, '0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (o_mem_req === 1'b1 && o_mem_addr === 32'h0000_7700) cnt++;
    end
    tests_run++;
    if (cnt != 300 || n_resp != p0 || o_mem_error !== 1'b0) begin
      fails++; $display("FAIL stall_forever: req_cycles=%0d responses=%0d err=%b required 300 0 0",
                        cnt, n_resp - p0, o_mem_error);
    end
    ready_mode = 0;
    wait_resp(n_resp + 1, 60, ok);
    i_miss_req = 1'b0;
    tests_run++;
    if (!ok) begin fails++; $display("FAIL stall_recover: no response after ready returned"); end
`endif
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_wb_stall();
    test_reset_mid_fill();
    test_held_req();
    test_timeout();
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || exp_resp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: wr=%0d rd=%0d resp=%0d required 0 0 0",
                        exp_wr_q.size(), exp_rd_q.size(), exp_resp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
